// File: rtl/output_buffer.sv
// output_buffer: collects one result matrix from the QR core, holds it, then streams it out in FIFO order.
module output_buffer #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int MATRIX_WORDS = 9,
    parameter int VEC_LEN      = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] R_i,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic                  done_vector,
    output logic                  done_store,
    input  logic                  start_unload,
    output logic [DATA_WIDTH-1:0] R_o,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  done_unload,
    output logic [ADDR_WIDTH-1:0] occupancy
);
    localparam logic [ADDR_WIDTH-1:0] M_WORDS = ADDR_WIDTH'(MATRIX_WORDS);
    localparam logic [ADDR_WIDTH-1:0] M_LAST  = ADDR_WIDTH'(MATRIX_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] V_LAST  = ADDR_WIDTH'(VEC_LEN - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE     = ADDR_WIDTH'(1);

    typedef enum logic [1:0] {COLLECT, HOLD, UNLOAD, DONE} state_t;
    state_t state, state_next;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, wr_cnt, rd_cnt, vec_cnt;
    logic accept, transfer, load;

    assign accept    = wr_valid && wr_ready;
    assign transfer  = out_valid && out_ready;
    // rd_ptr addresses the next word to load into the output register
    assign load      = state == UNLOAD && rd_ptr != M_WORDS && (!out_valid || out_ready);
    assign occupancy = wr_cnt - rd_cnt;

    always_comb begin
        state_next = state;
        case (state)
            COLLECT: state_next = (accept && wr_cnt == M_LAST) ? HOLD : COLLECT;
            HOLD:    state_next = start_unload ? UNLOAD : HOLD;
            UNLOAD:  state_next = (transfer && rd_cnt == M_LAST) ? DONE : UNLOAD;
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= COLLECT;
        else
            state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (accept)
            mem[wr_ptr] <= R_i;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ready    <= 1'b0;
            done_vector <= 1'b0;
            done_store  <= 1'b0;
            done_unload <= 1'b0;
            out_valid   <= 1'b0;
            R_o         <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_cnt      <= '0;
            rd_cnt      <= '0;
            vec_cnt     <= '0;
        end else begin
            wr_ready    <= state_next == COLLECT;
            done_store  <= state_next == HOLD || state_next == UNLOAD;
            done_vector <= accept && vec_cnt == V_LAST;
            done_unload <= transfer && rd_cnt == M_LAST;
            out_valid   <= load || (out_valid && !out_ready);
            if (state == DONE) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                wr_cnt  <= '0;
                rd_cnt  <= '0;
                vec_cnt <= '0;
            end else begin
                if (accept) begin
                    wr_ptr  <= wr_ptr + ONE;
                    wr_cnt  <= wr_cnt + ONE;
                    vec_cnt <= (vec_cnt == V_LAST) ? '0 : vec_cnt + ONE;
                end
                if (load) begin
                    R_o    <= mem[rd_ptr];
                    rd_ptr <= rd_ptr + ONE;
                end
                if (transfer)
                    rd_cnt <= rd_cnt + ONE;
            end
        end
    end
endmodule

// File: tb/tb_output_buffer.sv
// tb_output_buffer: directed scenarios plus randomized rounds checked against a queue model of the buffer.
module tb_output_buffer;
    localparam int DW = 16;
    localparam int AW = 4;
    localparam int MW = 9;

    logic          clk = 0, reset = 1;
    logic [DW-1:0] R_i = '0;
    logic          wr_valid = 0, start_unload = 0, out_ready = 0;
    logic          wr_ready, done_vector, done_store, out_valid, done_unload;
    logic [DW-1:0] R_o;
    logic [AW-1:0] occupancy;
    int            checks = 0, passed = 0;

    always #5 clk = ~clk;

    output_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MATRIX_WORDS(MW), .VEC_LEN(3)) dut (
        .clk(clk), .reset(reset), .R_i(R_i), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .done_vector(done_vector), .done_store(done_store), .start_unload(start_unload),
        .R_o(R_o), .out_valid(out_valid), .out_ready(out_ready), .done_unload(done_unload),
        .occupancy(occupancy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int base);
        for (int i = 0; i < MW; i++) begin
            wr_valid = 1;
            R_i = DW'(base + i);
            step();
        end
        wr_valid = 0;
    endtask

    task automatic start();
        start_unload = 1;
        step();
        start_unload = 0;
        step();
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({wr_ready, done_vector, done_store, out_valid, done_unload, R_o, occupancy} !== '0)
            $display("FAIL reset_outputs: got %b want all zero",
                     {wr_ready, done_vector, done_store, out_valid, done_unload, R_o, occupancy});
        else passed++;
        @(posedge clk);
        #1;
        reset = 0;
        step();
        checks++;
        if (wr_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", wr_ready);
        else passed++;
    endtask

    task automatic test_collect();
        for (int i = 1; i <= MW; i++) begin
            wr_valid = 1;
            R_i = DW'(i);
            step();
            checks++;
            if (done_vector !== (i % 3 == 0))
                $display("FAIL collect_done_vector word %0d: got %b want %b", i, done_vector, i % 3 == 0);
            else passed++;
            checks++;
            if (occupancy !== AW'(i)) $display("FAIL collect_occupancy word %0d: got %0d want %0d", i, occupancy, i);
            else passed++;
        end
        wr_valid = 0;
        checks++;
        if ({done_store, wr_ready} !== 2'b10)
            $display("FAIL collect_hold: got store/ready %b want 10", {done_store, wr_ready});
        else passed++;
    endtask

    task automatic test_unload();
        start_unload = 1;
        step();
        start_unload = 0;
        out_ready = 1;
        checks++;
        if (out_valid !== 1'b0) $display("FAIL unload_first_cycle_valid: got %b want 0", out_valid);
        else passed++;
        step();
        for (int k = 1; k <= MW; k++) begin
            checks++;
            if ({out_valid, R_o} !== {1'b1, DW'(k)})
                $display("FAIL unload_word %0d: got valid %b data %0d want valid 1 data %0d", k, out_valid, R_o, k);
            else passed++;
            step();
        end
        checks++;
        if ({out_valid, done_unload, occupancy} !== {2'b01, AW'(0)})
            $display("FAIL unload_end: got valid %b done %b occ %0d want 0 1 0", out_valid, done_unload, occupancy);
        else passed++;
        step();
        checks++;
        if ({done_unload, wr_ready, done_store} !== 3'b010)
            $display("FAIL unload_return: got done/ready/store %b want 010", {done_unload, wr_ready, done_store});
        else passed++;
    endtask

    task automatic test_backpressure();
        fill(1);
        start();
        out_ready = 1;
        step();
        step();
        step();
        out_ready = 0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({out_valid, R_o} !== {1'b1, DW'(4)})
                $display("FAIL stall_hold cycle %0d: got valid %b data %0d want 1 4", s, out_valid, R_o);
            else passed++;
            step();
        end
        out_ready = 1;
        for (int k = 4; k <= MW; k++) begin
            checks++;
            if ({out_valid, R_o} !== {1'b1, DW'(k)})
                $display("FAIL stall_resume word %0d: got valid %b data %0d", k, out_valid, R_o);
            else passed++;
            step();
        end
        checks++;
        if (done_unload !== 1'b1) $display("FAIL stall_done_unload: got %b want 1", done_unload);
        else passed++;
        out_ready = 0;
        step();
    endtask

    task automatic test_start_ignored();
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1;
            R_i = DW'(21 + i);
            step();
        end
        wr_valid = 0;
        start_unload = 1;
        step();
        start_unload = 0;
        step();
        checks++;
        if ({out_valid, wr_ready, occupancy} !== {2'b01, AW'(5)})
            $display("FAIL start_in_collect: got valid %b ready %b occ %0d want 0 1 5", out_valid, wr_ready, occupancy);
        else passed++;
        for (int i = 5; i < MW; i++) begin
            wr_valid = 1;
            start_unload = (i == MW - 1);
            R_i = DW'(21 + i);
            step();
        end
        wr_valid = 0;
        start_unload = 0;
        for (int s = 0; s < 3; s++) begin
            checks++;
            if ({out_valid, done_store} !== 2'b01)
                $display("FAIL start_with_last_word cycle %0d: got valid/store %b want 01", s, {out_valid, done_store});
            else passed++;
            step();
        end
        start();
        out_ready = 1;
        for (int k = 0; k < MW; k++) begin
            checks++;
            if ({out_valid, R_o} !== {1'b1, DW'(21 + k)})
                $display("FAIL start_ignored_order word %0d: got valid %b data %0d want %0d", k, out_valid, R_o, 21 + k);
            else passed++;
            step();
        end
        out_ready = 0;
        step();
    endtask

    task automatic test_drop_in_hold();
        fill(1);
        wr_valid = 1;
        R_i = DW'(99);
        for (int s = 0; s < 3; s++) step();
        wr_valid = 0;
        checks++;
        if ({occupancy, wr_ready} !== {AW'(9), 1'b0})
            $display("FAIL hold_drop: got occ %0d ready %b want 9 0", occupancy, wr_ready);
        else passed++;
        start();
        out_ready = 1;
        for (int k = 1; k <= MW; k++) begin
            checks++;
            if ({out_valid, R_o} !== {1'b1, DW'(k)})
                $display("FAIL hold_drop_order word %0d: got valid %b data %0d", k, out_valid, R_o);
            else passed++;
            step();
        end
        out_ready = 0;
        step();
    endtask

    task automatic test_reset_mid_unload();
        fill(1);
        start();
        out_ready = 1;
        for (int k = 0; k < 6; k++) step();
        out_ready = 0;
        reset = 1;
        #1;
        checks++;
        if ({wr_ready, done_vector, done_store, out_valid, done_unload, R_o, occupancy} !== '0)
            $display("FAIL reset_mid_unload: got %b want all zero",
                     {wr_ready, done_vector, done_store, out_valid, done_unload, R_o, occupancy});
        else passed++;
        @(posedge clk);
        #1;
        reset = 0;
        step();
        checks++;
        if ({wr_ready, out_valid, occupancy} !== {2'b10, AW'(0)})
            $display("FAIL reset_mid_recover: got ready %b valid %b occ %0d", wr_ready, out_valid, occupancy);
        else passed++;
        fill(10);
        start();
        out_ready = 1;
        for (int k = 10; k <= 18; k++) begin
            checks++;
            if ({out_valid, R_o} !== {1'b1, DW'(k)})
                $display("FAIL fresh_matrix word %0d: got valid %b data %0d", k, out_valid, R_o);
            else passed++;
            step();
        end
        out_ready = 0;
        step();
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            logic [DW-1:0] q[$];
            int budget = 0;
            logic popped;
            while (q.size() < MW && budget < 200) begin
                wr_valid = 1'($urandom_range(0, 1));
                start_unload = 1'($urandom_range(0, 1));
                R_i = DW'($urandom);
                checks++;
                if (wr_ready !== 1'b1) $display("FAIL rand_ready round %0d: got %b want 1", r, wr_ready);
                else passed++;
                if (wr_valid) q.push_back(R_i);
                step();
                checks++;
                if (occupancy !== AW'(q.size())) $display("FAIL rand_occ_fill: got %0d want %0d", occupancy, q.size());
                else passed++;
                budget++;
            end
            start_unload = 0;
            repeat ($urandom_range(0, 3)) begin
                wr_valid = 1;
                R_i = DW'($urandom);
                step();
            end
            wr_valid = 0;
            checks++;
            if ({done_store, out_valid, occupancy} !== {2'b10, AW'(MW)})
                $display("FAIL rand_hold: got store %b valid %b occ %0d", done_store, out_valid, occupancy);
            else passed++;
            start_unload = 1;
            step();
            start_unload = 0;
            budget = 0;
            while (q.size() > 0 && budget < 200) begin
                out_ready = 1'($urandom_range(0, 1));
                popped = 0;
                if (out_valid) begin
                    checks++;
                    if (R_o !== q[0]) $display("FAIL rand_data: got %0h want %0h", R_o, q[0]);
                    else passed++;
                    if (out_ready) begin
                        void'(q.pop_front());
                        popped = 1;
                    end
                end
                step();
                checks++;
                if ({done_unload, occupancy} !== {popped && q.size() == 0, AW'(q.size())})
                    $display("FAIL rand_unload_status: got done %b occ %0d want %b %0d",
                             done_unload, occupancy, popped && q.size() == 0, q.size());
                else passed++;
                budget++;
            end
            checks++;
            if (q.size() != 0) $display("FAIL rand_timeout: %0d words left, want 0", q.size());
            else passed++;
            out_ready = 0;
            step();
        end
    endtask

    initial begin
        test_reset();
        test_collect();
        test_unload();
        test_backpressure();
        test_start_ignored();
        test_drop_in_hold();
        test_reset_mid_unload();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
